// File: rtl/step_sequencer.sv
// Timestep controller for the 10-bit processor front end: step-key edge detect,
// T0..T3 sequencing, external-input path control and completed-instruction count.
module step_sequencer #(
  parameter logic [3:0] LOAD_OPC = 4'b0000,
  parameter int         CNT_W    = 8
) (
  input  logic             CLK_50MHz,
  input  logic             Reset_n,
  input  logic             StepKey,
  input  logic             PeekKey,
  input  logic [9:0]       Instr,
  output logic [3:0]       Timestep,
  output logic             Extrn_Enable,
  output logic             IR_Load,
  output logic             Done,
  output logic             Peek_Active,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  state_t state, next_state;
  logic   step_q;
  logic   armed;
  logic   step_evt;
  logic   accepted;
  logic   is_load;
  logic   peek_next;
  logic   ir_load_next;
  logic   done_next;
  logic   extrn_next;

  // The first post-reset cycle only loads step_q, so a key held through reset
  // must be released and pressed again before it counts.
  assign step_evt = StepKey & ~step_q & armed;
  assign accepted = step_evt & ~Peek_Active;
  assign is_load  = (Instr[9:6] == LOAD_OPC);

  always_comb begin
    next_state   = state;
    ir_load_next = 1'b0;
    done_next    = 1'b0;
    if (accepted) begin
      case (state)
        T0: begin
          next_state   = T1;
          ir_load_next = 1'b1;
        end
        T1: begin
          if (is_load) begin
            next_state = T0;
            done_next  = 1'b1;
          end else begin
            next_state = T2;
          end
        end
        T2: next_state = T3;
        T3: begin
          next_state = T0;
          done_next  = 1'b1;
        end
        default: next_state = T0;
      endcase
    end
  end

  // Peek is only honoured while sitting in T0; elsewhere it is forced off.
  always_comb begin
    peek_next  = (next_state == T0) & PeekKey;
    extrn_next = ((next_state == T0) & ~peek_next) |
                 ((next_state == T1) & is_load);
  end

  always_comb begin
    case (state)
      T0:      Timestep = 4'b0001;
      T1:      Timestep = 4'b0010;
      T2:      Timestep = 4'b0100;
      T3:      Timestep = 4'b1000;
      default: Timestep = 4'b0001;
    endcase
  end

  always_ff @(posedge CLK_50MHz or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= T0;
      step_q       <= 1'b0;
      armed        <= 1'b0;
      Peek_Active  <= 1'b0;
      Extrn_Enable <= 1'b0;
      IR_Load      <= 1'b0;
      Done         <= 1'b0;
      InstrCount   <= '0;
    end else begin
      state        <= next_state;
      step_q       <= StepKey;
      armed        <= 1'b1;
      Peek_Active  <= peek_next;
      Extrn_Enable <= extrn_next;
      IR_Load      <= ir_load_next;
      Done         <= done_next;
      if (done_next) begin
        InstrCount <= InstrCount + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule
